// File: rtl/mop_thread_issuer.sv
// Multi-thread micro-op issuer: one FIFO per thread, one issue per cycle,
// round-robin among threads whose lockout counter has expired.
module mop_thread_issuer #(
   parameter int N_THR = 6,
   parameter int DEPTH = 16,
   parameter int MOP_W = 49,
   parameter int LAT   = 82,
   localparam int THR_W = (N_THR > 1) ? $clog2(N_THR) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [THR_W-1:0]   in_thr,
   input  logic [MOP_W-1:0]   in_mop,
   output logic [N_THR-1:0]   in_ready,
   input  logic [N_THR-1:0]   flush,
   output logic               out_valid,
   output logic [THR_W-1:0]   out_thr,
   output logic [MOP_W-1:0]   out_mop,
   output logic [N_THR-1:0]   thr_idle
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [AW:0]      PTR_ZERO   = {(AW+1){1'b0}};
   localparam logic [AW:0]      PTR_ONE    = (AW+1)'(1);
   localparam logic [THR_W-1:0] RR_INIT    = THR_W'(N_THR - 1);
   localparam logic [THR_W-1:0] THR_ZERO   = {THR_W{1'b0}};
   localparam logic [MOP_W-1:0] MOP_ZERO   = {MOP_W{1'b0}};

   // Storage and per-thread state.
   logic [MOP_W-1:0] mem_r    [N_THR][DEPTH];
   logic [AW:0]      wr_ptr_r [N_THR];
   logic [AW:0]      rd_ptr_r [N_THR];
   logic [CNT_W-1:0] cnt_r    [N_THR];
   logic [THR_W-1:0] rr_r;

   logic [N_THR-1:0] empty_s;
   logic [N_THR-1:0] full_s;
   logic [N_THR-1:0] ready_s;
   logic [N_THR-1:0] push_s;
   logic [N_THR-1:0] elig_s;
   logic [N_THR-1:0] idle_s;
   logic             grant_s;
   logic [THR_W-1:0] gnt_thr_s;
   logic [THR_W-1:0] cand_s;
   logic [MOP_W-1:0] head_mop_s;

   // Per-thread FIFO status, push acceptance and issue eligibility.
   always_comb begin
      empty_s = {N_THR{1'b0}};
      full_s  = {N_THR{1'b0}};
      ready_s = {N_THR{1'b0}};
      push_s  = {N_THR{1'b0}};
      elig_s  = {N_THR{1'b0}};
      idle_s  = {N_THR{1'b0}};
      for (int i = 0; i < N_THR; i++) begin
         empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
         // Same slot index but different wrap bit means the FIFO is full.
         full_s[i]  = (wr_ptr_r[i][AW] != rd_ptr_r[i][AW]) &&
                      (wr_ptr_r[i][AW-1:0] == rd_ptr_r[i][AW-1:0]);
         ready_s[i] = !full_s[i] && !flush[i];
         push_s[i]  = in_valid && (in_thr == THR_W'(i)) && ready_s[i];
         elig_s[i]  = !empty_s[i] && (cnt_r[i] == CNT_ZERO) && !flush[i];
         idle_s[i]  = empty_s[i] && (cnt_r[i] == CNT_ZERO);
      end
   end

   assign in_ready = ready_s;
   assign thr_idle = idle_s;

   // Round-robin search starting just after the last granted thread.
   always_comb begin
      grant_s   = 1'b0;
      gnt_thr_s = rr_r;
      cand_s    = rr_r;
      for (int k = 1; k <= N_THR; k++) begin
         cand_s = THR_W'((int'(rr_r) + k) % N_THR);
         if (!grant_s && elig_s[cand_s]) begin
            grant_s   = 1'b1;
            gnt_thr_s = cand_s;
         end else begin
            grant_s   = grant_s;
         end
      end
      head_mop_s = mem_r[gnt_thr_s][rd_ptr_r[gnt_thr_s][AW-1:0]];
   end

   // FIFO data array write; contents need no reset since pointers gate reads.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_THR; i++) begin
         if (push_s[i]) begin
            mem_r[i][wr_ptr_r[i][AW-1:0]] <= in_mop;
         end
      end
   end

   // Pointers, lockout counters, arbiter pointer and registered issue port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_THR; i++) begin
            wr_ptr_r[i] <= PTR_ZERO;
            rd_ptr_r[i] <= PTR_ZERO;
            cnt_r[i]    <= CNT_ZERO;
         end
         rr_r      <= RR_INIT;
         out_valid <= 1'b0;
         out_thr   <= THR_ZERO;
         out_mop   <= MOP_ZERO;
      end else begin
         for (int i = 0; i < N_THR; i++) begin
            // Flush empties the FIFO by catching the read pointer up.
            if (flush[i]) begin
               rd_ptr_r[i] <= wr_ptr_r[i];
            end else if (grant_s && (gnt_thr_s == THR_W'(i))) begin
               rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
            end else begin
               rd_ptr_r[i] <= rd_ptr_r[i];
            end

            if (push_s[i]) begin
               wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
            end else begin
               wr_ptr_r[i] <= wr_ptr_r[i];
            end

            // A flushed thread is never granted, so reload and clear are exclusive.
            if (grant_s && (gnt_thr_s == THR_W'(i))) begin
               cnt_r[i] <= CNT_RELOAD;
            end else if (flush[i]) begin
               cnt_r[i] <= CNT_ZERO;
            end else if (cnt_r[i] != CNT_ZERO) begin
               cnt_r[i] <= cnt_r[i] - CNT_ONE;
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end

         out_valid <= grant_s;
         if (grant_s) begin
            rr_r    <= gnt_thr_s;
            out_thr <= gnt_thr_s;
            out_mop <= head_mop_s;
         end else begin
            rr_r    <= rr_r;
            out_thr <= out_thr;
            out_mop <= out_mop;
         end
      end
   end

endmodule
